// File: rtl/fc_align_pkg.sv
// Shared state encoding and default idle pattern for the fast-command word aligner.
package fc_align_pkg;

  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_LOCKED = 2'd1,
    ST_MANUAL = 2'd2
  } fc_state_e;

  localparam logic [7:0] FC_IDLE_DEFAULT = 8'hF0;

endpackage

// File: rtl/fc_word_capture.sv
// Serial-to-parallel front end: shift register, free bit counter and word capture
// register that fires one cycle after the bit counter meets the requested phase.
module fc_word_capture #(
  parameter int WORD_W = 8,
  parameter int PH_W   = $clog2(WORD_W)
) (
  input  logic              clk320,
  input  logic              rst,
  input  logic              fc_i,
  input  logic [PH_W-1:0]   phase_i,
  output logic [WORD_W-1:0] word_o,
  output logic              strobe_o
);

  logic [WORD_W-1:0] shift_q, shift_d;
  logic [WORD_W-1:0] word_q, word_d;
  logic [PH_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic              strobe_q, strobe_d;

  always_comb begin
    shift_d   = {shift_q[WORD_W-2:0], fc_i};
    bit_cnt_d = (bit_cnt_q == PH_W'(WORD_W - 1)) ? '0 : bit_cnt_q + 1'b1;
    strobe_d  = (bit_cnt_q == phase_i);
    word_d    = strobe_d ? shift_q : word_q;
  end

  always_ff @(posedge clk320) begin
    if (rst) begin
      shift_q   <= '0;
      bit_cnt_q <= '0;
      word_q    <= '0;
      strobe_q  <= 1'b0;
    end else begin
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      word_q    <= word_d;
      strobe_q  <= strobe_d;
    end
  end

  assign word_o   = word_q;
  assign strobe_o = strobe_q;

endmodule

// File: rtl/fc_auto_align.sv
// Fast-command word aligner: searches for the idle pattern by slipping the word
// boundary, holds lock until repeated rotated idles are seen, or follows a manual phase.
//
// state  | meaning
// SEARCH | slipping phase one bit per mismatching capture until LOCK_COUNT idles in a row
// LOCKED | boundary trusted; rotated idles counted, UNLOCK_COUNT in a row drop back to SEARCH
// MANUAL | phase forced from manualPhase, no search, locked low
module fc_auto_align
  import fc_align_pkg::*;
#(
  parameter int                WORD_W       = 8,
  parameter logic [WORD_W-1:0] IDLE_WORD    = FC_IDLE_DEFAULT,
  parameter int                LOCK_COUNT   = 16,
  parameter int                UNLOCK_COUNT = 4,
  localparam int               PH_W         = $clog2(WORD_W)
) (
  input  logic              clk320,
  input  logic              rst,
  input  logic              fc,
  input  logic              manualMode,
  input  logic [PH_W-1:0]   manualPhase,
  output logic [WORD_W-1:0] fcd,
  output logic              fcdValid,
  output logic              locked,
  output logic [PH_W-1:0]   phase,
  output logic [7:0]        errCount
);

  localparam logic [7:0] LOCK_LAST   = 8'(LOCK_COUNT - 1);
  localparam logic [7:0] UNLOCK_LAST = 8'(UNLOCK_COUNT - 1);

  fc_state_e         state_q, state_d;
  logic [PH_W-1:0]   phase_q, phase_d, phase_inc;
  logic [7:0]        match_q, match_d;
  logic [7:0]        rot_q, rot_d;
  logic [7:0]        err_q, err_d;
  logic [WORD_W-1:0] cap_word;
  logic              cap_strobe;
  logic              is_rot;

  fc_word_capture #(
    .WORD_W (WORD_W),
    .PH_W   (PH_W)
  ) u_capture (
    .clk320   (clk320),
    .rst      (rst),
    .fc_i     (fc),
    .phase_i  (phase_q),
    .word_o   (cap_word),
    .strobe_o (cap_strobe)
  );

  // A rotation that lands back on the idle pattern is an aligned idle, not an error.
  always_comb begin
    is_rot = 1'b0;
    for (int k = 1; k < WORD_W; k++) begin
      if (cap_word == ((IDLE_WORD << k) | (IDLE_WORD >> (WORD_W - k)))) is_rot = 1'b1;
    end
    if (cap_word == IDLE_WORD) is_rot = 1'b0;
  end

  assign phase_inc = (phase_q == PH_W'(WORD_W - 1)) ? '0 : phase_q + 1'b1;

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    match_d = match_q;
    rot_d   = rot_q;
    err_d   = err_q;
    if (cap_strobe) begin
      unique case (state_q)
        ST_SEARCH: begin
          if (cap_word == IDLE_WORD) begin
            if (match_q == LOCK_LAST) begin
              state_d = ST_LOCKED;
              match_d = '0;
              rot_d   = '0;
            end else begin
              match_d = match_q + 8'd1;
            end
          end else begin
            match_d = '0;
            phase_d = phase_inc;
          end
        end
        ST_LOCKED: begin
          if (is_rot) begin
            err_d = (err_q == 8'hFF) ? err_q : err_q + 8'd1;
            if (rot_q == UNLOCK_LAST) begin
              state_d = ST_SEARCH;
              phase_d = phase_inc;
              rot_d   = '0;
              match_d = '0;
            end else begin
              rot_d = rot_q + 8'd1;
            end
          end else if (cap_word == IDLE_WORD) begin
            rot_d = '0;
          end
        end
        default: ;
      endcase
    end
    // Manual control overrides whatever the capture decided this cycle.
    if (manualMode) begin
      state_d = ST_MANUAL;
      phase_d = manualPhase;
      match_d = '0;
      rot_d   = '0;
    end else if (state_q == ST_MANUAL) begin
      state_d = ST_SEARCH;
      match_d = '0;
    end
  end

  always_ff @(posedge clk320) begin
    if (rst) begin
      state_q <= ST_SEARCH;
      phase_q <= '0;
      match_q <= '0;
      rot_q   <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      match_q <= match_d;
      rot_q   <= rot_d;
      err_q   <= err_d;
    end
  end

  assign fcd      = cap_word;
  assign fcdValid = cap_strobe;
  assign locked   = (state_q == ST_LOCKED);
  assign phase    = phase_q;
  assign errCount = err_q;

endmodule

// File: tb/tb_fc_auto_align.sv
// Scoreboard bench for fc_auto_align: an 8-bit and a 10-bit instance driven from
// word-level streams, checked against a word-level model of the alignment rules.
module tb_fc_auto_align;

  typedef struct {
    int word;
    int due;
  } exp_t;

  logic        clk320 = 1'b0;
  logic        rst = 1'b1;
  logic        fc0 = 1'b0, fc1 = 1'b0;
  logic        manualMode = 1'b0;
  logic [2:0]  mp0 = '0;
  logic [3:0]  mp1 = '0;
  logic [7:0]  fcd0, ec0, ec1;
  logic [9:0]  fcd1;
  logic        v0, v1, lk0, lk1;
  logic [2:0]  ph0;
  logic [3:0]  ph1;

  fc_auto_align dut0 (
    .clk320(clk320), .rst(rst), .fc(fc0), .manualMode(manualMode), .manualPhase(mp0),
    .fcd(fcd0), .fcdValid(v0), .locked(lk0), .phase(ph0), .errCount(ec0)
  );

  fc_auto_align #(.WORD_W(10), .IDLE_WORD(10'h3E0)) dut1 (
    .clk320(clk320), .rst(rst), .fc(fc1), .manualMode(manualMode), .manualPhase(mp1),
    .fcd(fcd1), .fcdValid(v1), .locked(lk1), .phase(ph1), .errCount(ec1)
  );

  initial forever #2 clk320 = ~clk320;

  int n_cmp = 0, n_bad = 0;
  int ecnt = 0, ncyc = 0;
  int base0 = 0, base1 = 0;
  int ovr0 [int];
  int garb1 [30];
  exp_t q0[$], q1[$];
  bit mon_en = 0, saw_wrap = 0;
  int prev_ph1 = 0;

  // model state: 0 search, 1 locked, 2 manual
  int MW [2] = '{8, 10};
  int MIDLE [2] = '{'hF0, 'h3E0};
  int m_st[2], m_ph[2], m_sh[2], m_cyc[2], m_mc[2], m_rc[2], m_err[2], m_pend[2], m_pw[2];
  bit m_rst_last = 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic bit is_rotated_idle(int wd, int idle, int w);
    longint dbl;
    longint mask;
    mask = (longint'(1) << w) - 1;
    if (wd == idle) return 0;
    dbl = (longint'(wd) << w) | longint'(wd);
    for (int j = 1; j < w; j++)
      if (((dbl >> j) & mask) == longint'(idle)) return 1;
    return 0;
  endfunction

  // Reference model: word-level alignment rules advanced once per clock.
  initial forever begin
    int w, idle, mask, fcb, cap, cw, mpv;
    exp_t e;
    @(posedge clk320);
    ecnt++;
    m_rst_last = rst;
    for (int i = 0; i < 2; i++) begin
      w = MW[i]; idle = MIDLE[i]; mask = (1 << w) - 1;
      fcb = (i == 0) ? int'(fc0) : int'(fc1);
      mpv = (i == 0) ? int'(mp0) : int'(mp1);
      if (rst) begin
        m_st[i] = 0; m_ph[i] = 0; m_sh[i] = 0; m_cyc[i] = 0;
        m_mc[i] = 0; m_rc[i] = 0; m_err[i] = 0; m_pend[i] = 0; m_pw[i] = 0;
      end else begin
        cap = ((m_cyc[i] % w) == m_ph[i]) ? 1 : 0;
        cw  = m_sh[i];
        if (m_pend[i] != 0) begin
          if (m_st[i] == 0) begin
            if (m_pw[i] == idle) begin
              m_mc[i]++;
              if (m_mc[i] == 16) begin m_st[i] = 1; m_mc[i] = 0; m_rc[i] = 0; end
            end else begin
              m_mc[i] = 0; m_ph[i] = (m_ph[i] + 1) % w;
            end
          end else if (m_st[i] == 1) begin
            if (is_rotated_idle(m_pw[i], idle, w)) begin
              m_rc[i]++;
              if (m_err[i] < 255) m_err[i]++;
              if (m_rc[i] == 4) begin
                m_st[i] = 0; m_ph[i] = (m_ph[i] + 1) % w; m_rc[i] = 0; m_mc[i] = 0;
              end
            end else if (m_pw[i] == idle) begin
              m_rc[i] = 0;
            end
          end
        end
        if (manualMode) begin
          m_st[i] = 2; m_ph[i] = mpv; m_mc[i] = 0; m_rc[i] = 0;
        end else if (m_st[i] == 2) begin
          m_st[i] = 0; m_mc[i] = 0;
        end
        if (cap != 0) begin
          e.word = cw; e.due = ecnt;
          if (i == 0) q0.push_back(e); else q1.push_back(e);
        end
        m_sh[i] = ((m_sh[i] << 1) | fcb) & mask;
        m_cyc[i]++;
        m_pend[i] = cap;
        m_pw[i] = cw;
      end
    end
  end

  task automatic mon_one(input int i, input logic v, input logic [31:0] fcd,
                         input logic [31:0] lk, input logic [31:0] ph, input logic [31:0] ec);
    exp_t e;
    bit have;
    have = (i == 0) ? (q0.size() > 0) : (q1.size() > 0);
    if (have) e = (i == 0) ? q0[0] : q1[0];
    if (v === 1'b1) begin
      if (!have) begin
        n_cmp++; n_bad++;
        $display("FAIL capture_unexpected[%0d]: fcdValid=1 but no capture required (t=%0t)", i, $time);
      end else begin
        if (i == 0) void'(q0.pop_front()); else void'(q1.pop_front());
        check($sformatf("fcd_word[%0d]", i), fcd, e.word);
        check($sformatf("fcd_time[%0d]", i), ecnt, e.due);
      end
    end else if (have && e.due <= ecnt) begin
      if (i == 0) void'(q0.pop_front()); else void'(q1.pop_front());
      n_cmp++; n_bad++;
      $display("FAIL capture_missing[%0d]: fcdValid=%b required 1 (t=%0t)", i, v, $time);
    end else begin
      check($sformatf("fcdValid_idle[%0d]", i), 32'(v), 0);
    end
    check($sformatf("locked[%0d]", i), lk, (m_st[i] == 1) ? 1 : 0);
    check($sformatf("phase[%0d]", i), ph, m_ph[i]);
    check($sformatf("errCount[%0d]", i), ec, m_err[i]);
  endtask

  initial forever begin
    @(negedge clk320);
    if (mon_en) begin
      mon_one(0, v0, 32'(fcd0), 32'(lk0), 32'(ph0), 32'(ec0));
      mon_one(1, v1, 32'(fcd1), 32'(lk1), 32'(ph1), 32'(ec1));
      if (prev_ph1 == 9 && ph1 == 4'd0 && m_st[1] == 0 && !m_rst_last) saw_wrap = 1;
      prev_ph1 = int'(ph1);
    end
  end

  task automatic drive_fc();
    int d, slot, pos, wd;
    d = ncyc - base0 + 8 * 100000; slot = d / 8 - 100000; pos = d % 8;
    wd = ovr0.exists(slot) ? ovr0[slot] : 'hF0;
    fc0 = ((wd >> (7 - pos)) & 1) != 0;
    d = ncyc - base1 + 10 * 100000; slot = d / 10 - 100000; pos = d % 10;
    wd = (slot >= 0 && slot < 30) ? garb1[slot] : 'h3E0;
    fc1 = ((wd >> (9 - pos)) & 1) != 0;
  endtask

  task automatic tick();
    @(posedge clk320);
    #1;
    ncyc++;
    drive_fc();
  endtask

  task automatic release_rst();
    rst = 1'b0;
    base0 = ncyc + 3;
    base1 = ncyc + 3;
    ovr0.delete();
    foreach (garb1[k]) begin
      garb1[k] = int'($urandom_range(0, 1023));
      if (garb1[k] == 'h3E0) garb1[k] = 'h3E1;
    end
    drive_fc();
  endtask

  task automatic inject0(input int ahead, input int wd);
    int d;
    d = ncyc - base0 + 8 * 100000;
    ovr0[d / 8 - 100000 + ahead] = wd;
  endtask

  task automatic set_mp(input int v);
    mp0 = 3'(v);
    mp1 = 4'(v);
  endtask

  task automatic wait_lk(input int i, input int want, input int bound, output int cnt);
    cnt = 0;
    while (((i == 0) ? int'(lk0) : int'(lk1)) != want && cnt < bound) begin
      tick();
      cnt++;
    end
    check($sformatf("wait_locked[%0d]=%0d", i, want), (i == 0) ? 32'(lk0) : 32'(lk1), want);
  endtask

  function automatic int rot8(int k);
    return ((('hF0 << k) | ('hF0 >> (8 - k)))) & 'hFF;
  endfunction

  initial begin
    int cnt, kind, wd;
    int pat [7] = '{'h78, 'h78, 'h78, 'hF0, 'h78, 'h78, 'h78};
    repeat (3) tick();
    mon_en = 1;
    check("rst_fcd0", 32'(fcd0), 0);     check("rst_valid0", 32'(v0), 0);
    check("rst_locked0", 32'(lk0), 0);   check("rst_phase0", 32'(ph0), 0);
    check("rst_err0", 32'(ec0), 0);      check("rst_fcd1", 32'(fcd1), 0);
    check("rst_locked1", 32'(lk1), 0);   check("rst_phase1", 32'(ph1), 0);

    // Idle stream offset by three bits: three slips then sixteen idles.
    release_rst();
    wait_lk(0, 1, 400, cnt);
    check("lock_latency", cnt, 149);
    check("lock_phase", 32'(ph0), 3);
    check("lock_fcd", 32'(fcd0), 'hF0);

    // Four rotated idles drop lock and slip the phase.
    for (int k = 0; k < 4; k++) inject0(2 + k, 'h78);
    wait_lk(0, 0, 100, cnt);
    check("unlock_err", 32'(ec0), 4);
    check("unlock_phase", 32'(ph0), 4);
    wait_lk(0, 1, 600, cnt);
    check("relock_phase", 32'(ph0), 3);

    // An aligned idle between rotated runs resets the run length.
    for (int k = 0; k < 7; k++) inject0(2 + k, pat[k]);
    repeat (90) tick();
    check("split_run_locked", 32'(lk0), 1);
    check("split_run_err", 32'(ec0), 10);

    // Random word traffic while locked.
    for (int it = 0; it < 40; it++) begin
      kind = int'($urandom_range(0, 3));
      if (kind == 0) wd = 'hF0;
      else if (kind == 1) wd = rot8(int'($urandom_range(1, 7)));
      else wd = int'($urandom_range(0, 255));
      inject0(2, wd);
      repeat (8) tick();
    end
    if (lk0 !== 1'b1) wait_lk(0, 1, 800, cnt);

    // Manual mode.
    set_mp(5);
    manualMode = 1'b1;
    tick();
    check("manual_locked", 32'(lk0), 0);
    check("manual_phase", 32'(ph0), 5);
    for (int r = 0; r < 3; r++) begin
      cnt = 0;
      tick();
      cnt++;
      while (v0 !== 1'b1 && cnt < 20) begin tick(); cnt++; end
      if (r > 0) check("manual_interval", cnt, 8);
    end
    repeat (15) begin
      set_mp(int'($urandom_range(0, 7)));
      repeat ($urandom_range(1, 12)) tick();
    end
    set_mp(5);
    tick();
    manualMode = 1'b0;
    tick();
    check("release_phase0", 32'(ph0), 5);
    check("release_phase1", 32'(ph1), 5);
    check("release_locked", 32'(lk0), 0);
    wait_lk(0, 1, 800, cnt);
    check("post_manual_phase", 32'(ph0), 3);

    // Reset pulse while locked, then relock with the original timing.
    rst = 1'b1;
    tick();
    check("rstp_fcd0", 32'(fcd0), 0);    check("rstp_valid0", 32'(v0), 0);
    check("rstp_locked0", 32'(lk0), 0);  check("rstp_phase0", 32'(ph0), 0);
    check("rstp_err0", 32'(ec0), 0);     check("rstp_locked1", 32'(lk1), 0);
    check("rstp_phase1", 32'(ph1), 0);   check("rstp_valid1", 32'(v1), 0);
    release_rst();
    wait_lk(0, 1, 400, cnt);
    check("relock_latency", cnt, 149);
    check("relock_rst_phase", 32'(ph0), 3);
    check("relock_rst_fcd", 32'(fcd0), 'hF0);

    // 10-bit instance: garbage prefix forces the phase through the 9 -> 0 wrap.
    wait_lk(1, 1, 3000, cnt);
    check("w10_lock_phase", 32'(ph1), 3);
    check("w10_lock_fcd", 32'(fcd1), 'h3E0);
    check("w10_phase_wrap_seen", 32'(saw_wrap), 1);

    repeat (12) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
